// File: rtl/frame_sync_rx.sv
// rtl/frame_sync_rx.sv - serial deframer: sync hunt, length, payload words, CRC-8, commit-on-good FIFO
module frame_sync_rx #(
  parameter logic [15:0] SYNC_WORD = 16'hEB90,
  parameter int          DEPTH     = 16,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rx_start_pulse,
  input  logic        i_bit_valid,
  input  logic        i_bit_data,
  input  logic        i_rx_rd_en,
  output logic [31:0] o_rd_data,
  output logic        o_empty,
  output logic [7:0]  o_word_cnt,
  output logic        o_frame_done,
  output logic        o_crc_err,
  output logic        o_len_err,
  output logic        o_timeout,
  output logic        o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_HUNT, S_LEN, S_PAYLOAD, S_CRC} state_t;

  function automatic logic [7:0] crc8_bit(input logic [7:0] c, input logic b);
    crc8_bit = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  state_t          state_q, state_d;
  logic [14:0]     hunt_q, hunt_d;
  logic [31:0]     sh_q, sh_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      words_left_q, words_left_d;
  logic [7:0]      crc_q, crc_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   wr_tmp_q, wr_tmp_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            done_q, done_d;
  logic            crc_err_q, crc_err_d;
  logic            len_err_q, len_err_d;
  logic            timeout_q, timeout_d;

  logic [31:0]     mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;

  logic [PW-1:0]   ptr_diff;
  logic [8:0]      count;
  logic [8:0]      free_words;
  logic            empty;
  logic [31:0]     shifted;
  logic [7:0]      crc_next;
  logic            in_frame;

  // Only committed words (wr_ptr) count toward occupancy; staging is invisible.
  assign ptr_diff   = wr_ptr_q - rd_ptr_q;
  assign count      = 9'(ptr_diff);
  assign free_words = 9'(DEPTH) - count;
  assign empty      = (count == 9'd0);
  assign shifted    = {sh_q[30:0], i_bit_data};
  assign crc_next   = crc8_bit(crc_q, i_bit_data);
  assign in_frame   = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CRC);

  always_comb begin
    state_d      = state_q;
    hunt_d       = hunt_q;
    sh_d         = sh_q;
    bit_cnt_d    = bit_cnt_q;
    words_left_d = words_left_q;
    crc_d        = crc_q;
    timer_d      = timer_q;
    wr_ptr_d     = wr_ptr_q;
    wr_tmp_d     = wr_tmp_q;
    rd_ptr_d     = rd_ptr_q;
    done_d       = 1'b0;
    crc_err_d    = 1'b0;
    len_err_d    = 1'b0;
    timeout_d    = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = wr_tmp_q[AW-1:0];
    mem_wdata    = shifted;

    if (i_rx_rd_en && !empty) rd_ptr_d = rd_ptr_q + 1'b1;

    if (in_frame) begin
      if (i_bit_valid) begin
        timer_d = '0;
      end else if (timer_q == TMAX) begin
        wr_tmp_d  = wr_ptr_q;
        timeout_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_rx_start_pulse) begin
          state_d = S_HUNT;
          hunt_d  = '0;
        end
      end
      S_HUNT: begin
        if (i_bit_valid) begin
          hunt_d = {hunt_q[13:0], i_bit_data};
          if ({hunt_q, i_bit_data} == SYNC_WORD) begin
            state_d   = S_LEN;
            bit_cnt_d = '0;
            crc_d     = '0;
            timer_d   = '0;
            sh_d      = '0;
          end
        end
      end
      S_LEN: begin
        if (i_bit_valid) begin
          sh_d      = shifted;
          crc_d     = crc_next;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            if (shifted[7:0] == 8'd0 || {1'b0, shifted[7:0]} > free_words) begin
              len_err_d = 1'b1;
              state_d   = S_HUNT;
              hunt_d    = '0;
            end else begin
              words_left_d = shifted[7:0];
              state_d      = S_PAYLOAD;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (i_bit_valid) begin
          sh_d      = shifted;
          crc_d     = crc_next;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 5'd31) begin
            mem_we       = 1'b1;
            wr_tmp_d     = wr_tmp_q + 1'b1;
            bit_cnt_d    = '0;
            words_left_d = words_left_q - 1'b1;
            if (words_left_q == 8'd1) state_d = S_CRC;
          end
        end
      end
      S_CRC: begin
        if (i_bit_valid) begin
          sh_d      = shifted;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
            if (shifted[7:0] == crc_q) begin
              wr_ptr_d = wr_tmp_q;
              done_d   = 1'b1;
            end else begin
              wr_tmp_d  = wr_ptr_q;
              crc_err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hunt_q       <= '0;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      words_left_q <= '0;
      crc_q        <= '0;
      timer_q      <= '0;
      wr_ptr_q     <= '0;
      wr_tmp_q     <= '0;
      rd_ptr_q     <= '0;
      done_q       <= 1'b0;
      crc_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hunt_q       <= hunt_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      words_left_q <= words_left_d;
      crc_q        <= crc_d;
      timer_q      <= timer_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_tmp_q     <= wr_tmp_d;
      rd_ptr_q     <= rd_ptr_d;
      done_q       <= done_d;
      crc_err_q    <= crc_err_d;
      len_err_q    <= len_err_d;
      timeout_q    <= timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign o_rd_data    = empty ? 32'd0 : mem[rd_ptr_q[AW-1:0]];
  assign o_empty      = empty;
  assign o_word_cnt   = count[7:0];
  assign o_frame_done = done_q;
  assign o_crc_err    = crc_err_q;
  assign o_len_err    = len_err_q;
  assign o_timeout    = timeout_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_frame_sync_rx.sv
// tb/tb_frame_sync_rx.sv - directed bench for frame_sync_rx
module tb_frame_sync_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_rx_start_pulse = 1'b0;
  logic        i_bit_valid = 1'b0;
  logic        i_bit_data = 1'b0;
  logic        i_rx_rd_en = 1'b0;
  logic [31:0] o_rd_data;
  logic        o_empty;
  logic [7:0]  o_word_cnt;
  logic        o_frame_done, o_crc_err, o_len_err, o_timeout, o_busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] wbuf [16];

  frame_sync_rx dut (
    .clk(clk), .rst_n(rst_n), .i_rx_start_pulse(i_rx_start_pulse),
    .i_bit_valid(i_bit_valid), .i_bit_data(i_bit_data), .i_rx_rd_en(i_rx_rd_en),
    .o_rd_data(o_rd_data), .o_empty(o_empty), .o_word_cnt(o_word_cnt),
    .o_frame_done(o_frame_done), .o_crc_err(o_crc_err), .o_len_err(o_len_err),
    .o_timeout(o_timeout), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    c  = c << 1;
    if (fb) c = c ^ 8'h07;
    return c;
  endfunction

  task automatic arm();
    @(negedge clk); i_rx_start_pulse = 1'b1;
    @(negedge clk); i_rx_start_pulse = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk); i_rx_rd_en = 1'b1;
    @(negedge clk); i_rx_rd_en = 1'b0;
  endtask

  // Sends sync, length n, words wbuf[0..n-1] and CRC; nbits<0 sends all of it.
  task automatic send_frame(input int n, input int nbits, input bit flip, input bit pop_last);
    bit q[$];
    logic [15:0] sw;
    logic [7:0]  len8, c;
    logic [31:0] w;
    int lim;
    sw = 16'hEB90; len8 = 8'(n); c = 8'h00;
    for (int i = 15; i >= 0; i--) q.push_back(sw[i]);
    for (int i = 7; i >= 0; i--) begin q.push_back(len8[i]); c = crc_step(c, len8[i]); end
    for (int k = 0; k < n; k++) begin
      w = wbuf[k];
      for (int i = 31; i >= 0; i--) begin q.push_back(w[i]); c = crc_step(c, w[i]); end
    end
    if (flip) c[0] = ~c[0];
    for (int i = 7; i >= 0; i--) q.push_back(c[i]);
    lim = (nbits < 0) ? q.size() : nbits;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      i_bit_valid = 1'b1; i_bit_data = q[i];
      i_rx_rd_en = pop_last && (i == lim - 1);
    end
    @(negedge clk);
    i_bit_valid = 1'b0; i_bit_data = 1'b0; i_rx_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", o_busy); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %0b exp 1", o_empty); end
    checks++; if (o_word_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", o_word_cnt); end
    checks++; if (o_rd_data !== 32'd0) begin errors++; $display("FAIL rst_data got %h exp 0", o_rd_data); end
    checks++; if ({o_frame_done, o_crc_err, o_len_err, o_timeout} !== 4'b0000) begin
      errors++; $display("FAIL rst_pulses got %b exp 0000", {o_frame_done, o_crc_err, o_len_err, o_timeout}); end
  endtask

  task automatic test_good_frame();
    wbuf[0] = 32'h04030201; wbuf[1] = 32'h08070605;
    arm();
    send_frame(2, -1, 0, 0);
    checks++; if (o_frame_done !== 1'b1) begin errors++; $display("FAIL good_done got %0b exp 1", o_frame_done); end
    checks++; if (o_crc_err !== 1'b0) begin errors++; $display("FAIL good_crcerr got %0b exp 0", o_crc_err); end
    checks++; if (o_word_cnt !== 8'd2) begin errors++; $display("FAIL good_cnt got %0d exp 2", o_word_cnt); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL good_busy got %0b exp 0", o_busy); end
    @(negedge clk);
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL good_done_one got %0b exp 0", o_frame_done); end
    checks++; if (o_rd_data !== 32'h04030201) begin errors++; $display("FAIL good_w0 got %h exp 04030201", o_rd_data); end
    pop();
    checks++; if (o_rd_data !== 32'h08070605) begin errors++; $display("FAIL good_w1 got %h exp 08070605", o_rd_data); end
    checks++; if (o_word_cnt !== 8'd1) begin errors++; $display("FAIL good_cnt1 got %0d exp 1", o_word_cnt); end
    pop();
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL good_empty got %0b exp 1", o_empty); end
  endtask

  task automatic test_crc_err();
    wbuf[0] = 32'h04030201; wbuf[1] = 32'h08070605;
    arm();
    send_frame(2, -1, 1, 0);
    checks++; if (o_crc_err !== 1'b1) begin errors++; $display("FAIL crc_pulse got %0b exp 1", o_crc_err); end
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL crc_done got %0b exp 0", o_frame_done); end
    checks++; if (o_word_cnt !== 8'd0) begin errors++; $display("FAIL crc_cnt got %0d exp 0", o_word_cnt); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL crc_empty got %0b exp 1", o_empty); end
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL crc_busy got %0b exp 0", o_busy); end
    checks++; if (o_crc_err !== 1'b0) begin errors++; $display("FAIL crc_pulse_one got %0b exp 0", o_crc_err); end
  endtask

  task automatic test_partial_sync();
    logic [11:0] part;
    part = 12'hEB9;
    arm();
    for (int i = 11; i >= 0; i--) begin
      @(negedge clk); i_bit_valid = 1'b1; i_bit_data = part[i];
    end
    @(negedge clk); i_bit_valid = 1'b0;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL part_busy got %0b exp 1", o_busy); end
    wbuf[0] = 32'h08080408;
    send_frame(1, -1, 0, 0);
    checks++; if (o_frame_done !== 1'b1) begin errors++; $display("FAIL part_done got %0b exp 1", o_frame_done); end
    checks++; if (o_word_cnt !== 8'd1) begin errors++; $display("FAIL part_cnt got %0d exp 1", o_word_cnt); end
    checks++; if (o_rd_data !== 32'h08080408) begin errors++; $display("FAIL part_data got %h exp 08080408", o_rd_data); end
    pop();
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL part_empty got %0b exp 1", o_empty); end
  endtask

  task automatic test_len_err();
    arm();
    send_frame(0, 24, 0, 0);
    checks++; if (o_len_err !== 1'b1) begin errors++; $display("FAIL len0_pulse got %0b exp 1", o_len_err); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL len0_hunt got %0b exp 1", o_busy); end
    wbuf[0] = 32'hA5A50F0F;
    send_frame(1, -1, 0, 0);
    checks++; if (o_frame_done !== 1'b1) begin errors++; $display("FAIL len0_next got %0b exp 1", o_frame_done); end
    checks++; if (o_rd_data !== 32'hA5A50F0F) begin errors++; $display("FAIL len0_data got %h exp a5a50f0f", o_rd_data); end
    pop();
    for (int k = 0; k < 15; k++) wbuf[k] = 32'h100 + k;
    arm();
    send_frame(15, -1, 0, 0);
    checks++; if (o_word_cnt !== 8'd15) begin errors++; $display("FAIL fill_cnt got %0d exp 15", o_word_cnt); end
    arm();
    send_frame(2, 24, 0, 0);
    checks++; if (o_len_err !== 1'b1) begin errors++; $display("FAIL lenfull_pulse got %0b exp 1", o_len_err); end
    checks++; if (o_word_cnt !== 8'd15) begin errors++; $display("FAIL lenfull_cnt got %0d exp 15", o_word_cnt); end
    wbuf[0] = 32'hCAFEF00D;
    send_frame(1, -1, 0, 0);
    checks++; if (o_frame_done !== 1'b1) begin errors++; $display("FAIL lastslot_done got %0b exp 1", o_frame_done); end
    checks++; if (o_word_cnt !== 8'd16) begin errors++; $display("FAIL lastslot_cnt got %0d exp 16", o_word_cnt); end
    checks++; if (o_rd_data !== 32'h100) begin errors++; $display("FAIL fill_head got %h exp 100", o_rd_data); end
    for (int k = 0; k < 15; k++) pop();
    checks++; if (o_rd_data !== 32'hCAFEF00D) begin errors++; $display("FAIL fill_tail got %h exp cafef00d", o_rd_data); end
    pop();
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL fill_empty got %0b exp 1", o_empty); end
  endtask

  task automatic test_timeout();
    int cycles;
    wbuf[0] = 32'hDEADBEEF;
    arm();
    send_frame(1, 44, 0, 0);
    cycles = 0;
    while (o_timeout !== 1'b1 && cycles < 1200) begin
      @(negedge clk); cycles++;
    end
    checks++; if (cycles < 1020 || cycles > 1028) begin errors++; $display("FAIL tmo_cycles got %0d exp 1024", cycles); end
    checks++; if (o_word_cnt !== 8'd0) begin errors++; $display("FAIL tmo_cnt got %0d exp 0", o_word_cnt); end
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %0b exp 0", o_busy); end
    wbuf[0] = 32'h13579BDF;
    arm();
    send_frame(1, -1, 0, 0);
    checks++; if (o_frame_done !== 1'b1) begin errors++; $display("FAIL tmo_rearm got %0b exp 1", o_frame_done); end
    checks++; if (o_rd_data !== 32'h13579BDF) begin errors++; $display("FAIL tmo_data got %h exp 13579bdf", o_rd_data); end
    pop();
  endtask

  task automatic test_back_to_back();
    wbuf[0] = 32'h11111111;
    arm();
    send_frame(1, -1, 0, 0);
    wbuf[0] = 32'h22222222; wbuf[1] = 32'h33333333;
    arm();
    send_frame(2, -1, 0, 1);
    checks++; if (o_word_cnt !== 8'd2) begin errors++; $display("FAIL b2b_cnt got %0d exp 2", o_word_cnt); end
    checks++; if (o_rd_data !== 32'h22222222) begin errors++; $display("FAIL b2b_head got %h exp 22222222", o_rd_data); end
    pop(); pop();
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %0b exp 1", o_empty); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) wbuf[k] = 32'hF0 + k;
    arm();
    send_frame(3, -1, 0, 0);
    checks++; if (o_word_cnt !== 8'd3) begin errors++; $display("FAIL mid_pre_cnt got %0d exp 3", o_word_cnt); end
    arm();
    send_frame(2, 64, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++; if (o_word_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt got %0d exp 0", o_word_cnt); end
    checks++; if (o_busy !== 1'b0 || o_empty !== 1'b1) begin errors++; $display("FAIL mid_state got busy %0b empty %0b exp 0 1", o_busy, o_empty); end
    checks++; if (o_rd_data !== 32'd0) begin errors++; $display("FAIL mid_data got %h exp 0", o_rd_data); end
    @(negedge clk); rst_n = 1'b1;
    pop();
    checks++; if (o_word_cnt !== 8'd0 || o_empty !== 1'b1) begin errors++; $display("FAIL mid_pop got cnt %0d empty %0b exp 0 1", o_word_cnt, o_empty); end
    wbuf[0] = 32'h0BADCAFE;
    arm();
    send_frame(1, -1, 0, 0);
    checks++; if (o_rd_data !== 32'h0BADCAFE || o_word_cnt !== 8'd1) begin errors++; $display("FAIL mid_after got %h cnt %0d exp 0badcafe 1", o_rd_data, o_word_cnt); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_good_frame();
    test_crc_err();
    test_partial_sync();
    test_len_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sync_rx.md
Name: frame_sync_rx

Overview:
- Receive-side deframer for the single-bit serial link (bit_data/bit_valid) driven by the digital transmitter.
- Hunts for a sync word, then extracts the length byte, the 32-bit payload words and the CRC-8 trailer.
- Payload words go into an internal FIFO, committed only when the CRC passes.
- Sits between the serial link and the software-visible read port, alongside the existing digital receiver, as its framed, error-checked counterpart.

Parameters:
SYNC_WORD, 16'hEB90, frame sync pattern, MSB first
DEPTH, 16, FIFO depth in 32-bit words (power of 2, max 255)
TIMEOUT, 1024, maximum clk cycles between valid bits inside a frame before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_rx_start_pulse  in  1  arms the receiver (one-cycle pulse)
i_bit_valid  in  1  qualifies i_bit_data this cycle
i_bit_data  in  1  serial data bit
i_rx_rd_en  in  1  pop one word from the FIFO
o_rd_data  out  32  FIFO head word (show-ahead)
o_empty  out  1  no committed words
o_word_cnt  out  8  committed words in the FIFO
o_frame_done  out  1  one-cycle pulse: frame accepted
o_crc_err  out  1  one-cycle pulse: CRC mismatch, frame discarded
o_len_err  out  1  one-cycle pulse: length 0 or larger than free space
o_timeout  out  1  one-cycle pulse: bit gap exceeded TIMEOUT mid-frame
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; all pointers and counters 0.
  - All pulse outputs 0, o_busy 0, o_empty 1, o_word_cnt 0, o_rd_data 0.
- Bit order: MSB first for every field. Only cycles with i_bit_valid=1 consume a bit.
- States:
  - IDLE: wait for i_rx_start_pulse, then go to HUNT. i_rx_start_pulse in any other state is ignored.
  - HUNT: shift every valid bit into a 16-bit register. Register == SYNC_WORD on the cycle the last bit is shifted in -> LEN. No timeout in HUNT.
  - LEN: collect 8 bits into N.
    - N==0, or N > DEPTH - committed count: pulse o_len_err, go to HUNT.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: collect 32 bits per word.
    - Each completed word is written at a staging write pointer (wr_tmp). The committed pointer (wr_ptr) is not advanced.
    - After N words -> CRC.
  - CRC: collect 8 bits and compare with the running CRC-8.
    - CRC-8: poly 0x07, init 0x00, no reflection, no final XOR. Updated bitwise on every bit of the LEN and PAYLOAD fields. Sync bits are excluded.
    - Match: wr_ptr <= wr_tmp, pulse o_frame_done, go to IDLE.
    - Mismatch: wr_tmp <= wr_ptr (rollback), pulse o_crc_err, go to IDLE.
- Timeout:
  - In LEN, PAYLOAD or CRC, a cycle counter resets on each valid bit.
  - Reaching TIMEOUT: roll back wr_tmp, pulse o_timeout, go to IDLE.
- Pulse latency: each pulse is asserted the cycle after the final bit of the field is sampled.
- Read side:
  - o_rd_data = mem[rd_ptr], showing committed data only.
  - i_rx_rd_en with o_empty=1 is ignored (no pointer change, no error).
  - Pop while the deframer is writing: both proceed. o_word_cnt = wr_ptr - rd_ptr, held in a 9-bit internal count.
  - A commit and a pop in the same cycle must update o_word_cnt consistently (+N-1).
- Staging guarantee: the LEN free-space check ensures wr_tmp never overruns rd_ptr. Uncommitted words are never visible to the reader.
- Pointer width is log2(DEPTH)+1, wrapping naturally.

Test Plan:
1. Arm, send 0xEB90, N=2, words 0x04030201 and 0x08070605, correct CRC from the bench golden model -> o_frame_done pulses once; o_word_cnt=2; two pops return 0x04030201 then 0x08070605; o_empty=1 afterwards.
2. Same frame with the CRC LSB flipped -> o_crc_err pulse; o_word_cnt stays 0; o_empty=1; o_busy=0 the next cycle.
3. Arm, send 12 random bits containing a partial 0xEB9 pattern, then the full sync and N=1 word 0x08080408 with good CRC -> correct alignment; single word read back.
4. Arm, send sync, N=0 -> o_len_err; continue hunting; a following valid N=1 frame is accepted. Separately, fill 15 words, then send N=2 -> o_len_err.
5. Arm, send sync, N=1, then 20 payload bits, then idle for 1024 cycles -> o_timeout pulse; o_word_cnt unchanged; re-arm and a good frame is accepted.
6. Drop rst_n mid-PAYLOAD with 3 words committed -> outputs return to reset values immediately; o_word_cnt=0; i_rx_rd_en pulsed on the empty FIFO has no effect.
